mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter DW, default 16: data width.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter BURST_MAX, default 4: max beats per request (power of two, >=1).
REQ-004 Parameter TIMEOUT, default 15: ACCESS cycles without MFC before error; 0 disables timeout.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  1  start request, sampled only in IDLE.
REQ-008 we  in  1  1=write, 0=read; sampled with req.
REQ-009 addr  in  AW  base address; sampled with req.
REQ-010 len  in  clog2(BURST_MAX) (min 1)  beats minus one; sampled with req.
REQ-011 wdata  in  DW  write word for current beat, sampled in every ADDR cycle of a write.
REQ-012 mem_rdata  in  DW  memory read data, valid when MFC=1.
REQ-013 MFC  in  1  memory function complete.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at end of request (success or error).
REQ-016 err  out  1  one-cycle pulse, coincident with done, on timeout.
REQ-017 rvalid  out  1  one-cycle pulse per completed read beat; rdata valid.
REQ-018 rdata  out  DW  registered read word.
REQ-019 wnext  out  1  one-cycle pulse per completed write beat; requester presents next wdata.
REQ-020 ldMAR, ldMDR, rd, wr  out  1 each  memory-side controls; mem_addr out AW; mem_wdata out DW.

Function
REQ-021 States SHALL be IDLE, ADDR, ACCESS, STEP, DONE, ERR; outputs SHALL be Moore except ldMDR on reads.
REQ-022 IDLE: req=1 latches we/addr/len, clears beat counter and timer, next state ADDR; req=0 stays IDLE; MFC ignored.
REQ-023 ADDR (1 cycle): ldMAR=1, mem_addr=(base+beat) mod 2^AW; on write also ldMDR=1, mem_wdata=wdata; next ACCESS.
REQ-024 ACCESS: rd=!we, wr=we held every cycle; read ldMDR=MFC, rdata captures mem_rdata on MFC edge; MFC=1 -> STEP.
REQ-025 ACCESS timer SHALL increment each cycle MFC=0; timer reaching TIMEOUT (TIMEOUT!=0) -> ERR; MFC=1 in the same cycle wins (STEP).
REQ-026 STEP (1 cycle): rvalid=1 for reads, wnext=1 for writes; beat==len -> DONE, else beat+1, timer cleared, -> ADDR.
REQ-027 DONE (1 cycle): done=1, -> IDLE. ERR (1 cycle): done=1, err=1, remaining beats abandoned, -> IDLE.
REQ-028 Latency: single read with MFC in first ACCESS cycle: req at edge N -> ADDR N+1, ACCESS N+2, rvalid N+3, done N+4, IDLE N+5; each extra beat adds 3 cycles plus wait cycles.
REQ-029 req while busy SHALL be ignored; no queuing.
REQ-030 Address wrap past 2^AW-1 SHALL continue at 0 without error.
REQ-031 rd and wr SHALL never be high together; neither high outside ACCESS.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, clear beat counter, timer, latched request and rdata, from any state including mid-burst.
REQ-033 During and the cycle after reset: busy, done, err, rvalid, wnext, ldMAR, ldMDR, rd, wr = 0; mem_addr, mem_wdata = 0.

Structure
REQ-034 Package mem_seq_pkg SHALL hold the state enumeration and state-encoding width constant.
REQ-035 Timeout counter SHALL be sub-module mem_seq_timer (clear, enable, TIMEOUT parameter, expire output).

Verification
REQ-036 Single read: addr=0x0010, len=0, MFC high first ACCESS cycle, mem_rdata=0xBEEF -> rd 1 cycle, rvalid with rdata=0xBEEF at N+3, done at N+4.
REQ-037 Burst write: addr=0x0100, len=3, MFC after 2 wait cycles each beat -> mem_addr 0x0100..0x0103, four wnext pulses, one done, err=0.
REQ-038 Timeout: TIMEOUT=15, read, MFC held 0 -> rd high 15 cycles, then err=1 and done=1 same cycle, busy=0 next cycle.
REQ-039 Wrap and race: addr=0xFFFF, len=1, MFC on exact timeout cycle -> mem_addr 0xFFFF then 0x0000, err=0.
REQ-040 Mid-burst reset: rst during beat 2 of len=3 read -> all outputs 0 next cycle, IDLE; new req then completes normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding for the memory sequencer
package mem_seq_pkg;
  localparam int SW = 3;
  typedef enum logic [SW-1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_STEP,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/mem_seq_timer.sv
// mem_seq_timer: counts ACCESS wait cycles and flags the cycle that would reach TIMEOUT
// Ports: clk, rst, clr_i (restart count), en_i (count this cycle), expire_o (timeout now)
module mem_seq_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + TW'(1);
  end
  // Fires on the waiting cycle whose increment would make the count equal TIMEOUT
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_seq.sv
// mem_seq: burst memory access sequencer driving MAR/MDR-style memory controls
// Ports: clk/rst; request side req, we, addr, len, wdata -> busy, done, err, rvalid, rdata, wnext;
// memory side mem_rdata, MFC -> ldMAR, ldMDR, rd, wr, mem_addr, mem_wdata
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 15,
  localparam int LW       = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          MFC,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          wnext,
  output logic          ldMAR,
  output logic          ldMDR,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);
  state_e        state_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q, beat_q;
  logic [DW-1:0] rdata_q;
  logic          expire;
  mem_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != S_ACCESS),
    .en_i    (state_q == S_ACCESS && !MFC),
    .expire_o(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          we_q    <= we;
          addr_q  <= addr;
          len_q   <= len;
          beat_q  <= '0;
          state_q <= S_ADDR;
        end
        S_ADDR: state_q <= S_ACCESS;
        S_ACCESS: if (MFC) begin
          if (!we_q) rdata_q <= mem_rdata;
          state_q <= S_STEP;
        end else if (expire) state_q <= S_ERR;
        S_STEP: if (beat_q == len_q) state_q <= S_DONE;
        else begin
          beat_q  <= beat_q + LW'(1);
          state_q <= S_ADDR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE || state_q == S_ERR;
  assign err       = state_q == S_ERR;
  assign rvalid    = state_q == S_STEP && !we_q;
  assign wnext     = state_q == S_STEP && we_q;
  assign ldMAR     = state_q == S_ADDR;
  // Writes load MDR alongside MAR; reads load it when the memory answers
  assign ldMDR     = (state_q == S_ADDR && we_q) || (state_q == S_ACCESS && !we_q && MFC);
  assign rd        = state_q == S_ACCESS && !we_q;
  assign wr        = state_q == S_ACCESS && we_q;
  // Address arithmetic wraps naturally at AW bits
  assign mem_addr  = state_q == S_ADDR ? addr_q + AW'(beat_q) : '0;
  assign mem_wdata = state_q == S_ADDR && we_q ? wdata : '0;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard-driven checks of mem_seq request sequencing
module tb_mem_seq;
  localparam int DW = 16, AW = 16, BM = 4, TO = 15, LW = 2;
  logic clk = 1'b0;
  logic rst, req, we, MFC;
  logic [AW-1:0] addr, mem_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata, mem_rdata, rdata, mem_wdata;
  logic busy, done, err, rvalid, wnext, ldMAR, ldMDR, rd, wr;
  mem_seq #(.DW(DW), .AW(AW), .BURST_MAX(BM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len), .wdata(wdata),
    .mem_rdata(mem_rdata), .MFC(MFC), .busy(busy), .done(done), .err(err),
    .rvalid(rvalid), .rdata(rdata), .wnext(wnext), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .rd(rd), .wr(wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [AW-1:0] exp_addr[$], obs_addr[$];
  logic [DW-1:0] exp_data[$], obs_data[$];
  int n_rd, n_wnext, n_done, n_err, n_overlap, rv_cyc, done_cyc, err_cyc, busy_gap;
  logic busy_after, done_after;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                     input int wait_n, input logic [DW-1:0] base, input bit hold);
    int acc = 0, beat = -1, c = 0;
    bit fin = 0;
    obs_addr.delete();
    obs_data.delete();
    n_rd = 0; n_wnext = 0; n_done = 0; n_err = 0; n_overlap = 0; busy_gap = 0;
    rv_cyc = -1; done_cyc = -1; err_cyc = -1;
    req = 1'b1; we = w; addr = a; len = l; wdata = base; MFC = 1'b0;
    while (!fin && c < 400) begin
      tick;
      c++;
      if (hold) begin addr = ~a; we = ~w; end else req = 1'b0;
      if (ldMAR) begin
        beat++;
        obs_addr.push_back(mem_addr);
        if (w) obs_data.push_back(mem_wdata);
      end
      if (rvalid) begin
        obs_data.push_back(rdata);
        if (rv_cyc < 0) rv_cyc = c;
      end
      if (wnext) begin n_wnext++; wdata = base + DW'(n_wnext); end
      if (rd) n_rd++;
      if (rd && wr) n_overlap++;
      if (!busy) busy_gap++;
      if (err) begin n_err++; err_cyc = c; end
      if (done) begin n_done++; done_cyc = c; fin = 1; req = 1'b0; end
      if (rd || wr) begin
        MFC = (acc == wait_n);
        acc++;
        mem_rdata = base + DW'(beat);
      end else begin
        acc = 0;
        MFC = 1'b0;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_bound: no done within 400 cycles (got done=%0b, need 1)", done);
    end
    tick;
    busy_after = busy;
    done_after = done;
  endtask
  task automatic cmp_queues(input string name);
    while (exp_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front();
      o = obs_addr.size() > 0 ? obs_addr.pop_front() : 'x;
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s_addr: got %h need %h", name, o, e); end
    end
    while (exp_data.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp_data.pop_front();
      o = obs_data.size() > 0 ? obs_data.pop_front() : 'x;
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s_data: got %h need %h", name, o, e); end
    end
    checks++;
    if (obs_addr.size() + obs_data.size() != 0) begin
      errors++;
      $display("FAIL %s_extra: got %0d leftover beats need 0", name, obs_addr.size() + obs_data.size());
    end
  endtask
  function automatic logic [AW+DW+8:0] outs();
    return {busy, done, err, rvalid, wnext, ldMAR, ldMDR, rd, wr, mem_addr, mem_wdata};
  endfunction
  task automatic test_reset;
    rst = 1'b1; req = 1'b1; MFC = 1'b0;
    tick;
    tick;
    checks++;
    if (outs() !== '0 || rdata !== '0) begin
      errors++; $display("FAIL reset_outs: got %h rdata %h need 0", outs(), rdata);
    end
    rst = 1'b0; req = 1'b0; MFC = 1'b1;
    tick;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_after: got %h need 0", outs()); end
    tick;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_mfc: busy %b need 0", busy); end
    MFC = 1'b0;
  endtask
  task automatic test_single_read;
    exp_addr.push_back(16'h0010);
    exp_data.push_back(16'hBEEF);
    run(1'b0, 16'h0010, 2'd0, 0, 16'hBEEF, 0);
    cmp_queues("single");
    checks++;
    if (rv_cyc !== 3) begin errors++; $display("FAIL single_rvalid_cyc: got %0d need 3", rv_cyc); end
    checks++;
    if (done_cyc !== 4) begin errors++; $display("FAIL single_done_cyc: got %0d need 4", done_cyc); end
    checks++;
    if (n_rd !== 1) begin errors++; $display("FAIL single_rd_cycles: got %0d need 1", n_rd); end
    checks++;
    if (n_err !== 0 || busy_gap !== 0) begin
      errors++; $display("FAIL single_err_busy: err %0d busy_gap %0d need 0 0", n_err, busy_gap);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b need 0", busy_after); end
  endtask
  task automatic test_burst_write;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(16'h0100 + AW'(i));
      exp_data.push_back(16'hA000 + DW'(i));
    end
    run(1'b1, 16'h0100, 2'd3, 2, 16'hA000, 0);
    cmp_queues("burst");
    checks++;
    if (n_wnext !== 4) begin errors++; $display("FAIL burst_wnext: got %0d need 4", n_wnext); end
    checks++;
    if (n_done !== 1 || done_after !== 1'b0) begin
      errors++; $display("FAIL burst_done: got %0d after %b need 1 0", n_done, done_after);
    end
    checks++;
    if (n_err !== 0 || n_rd !== 0 || n_overlap !== 0) begin
      errors++; $display("FAIL burst_err_rd: err %0d rd %0d overlap %0d need 0", n_err, n_rd, n_overlap);
    end
  endtask
  task automatic test_timeout;
    exp_addr.push_back(16'h0040);
    run(1'b0, 16'h0040, 2'd2, -1, 16'h0, 0);
    cmp_queues("timeout");
    checks++;
    if (n_rd !== 15) begin errors++; $display("FAIL timeout_rd: got %0d cycles need 15", n_rd); end
    checks++;
    if (n_err !== 1 || err_cyc !== done_cyc) begin
      errors++; $display("FAIL timeout_err: err %0d at %0d, done at %0d need 1 same", n_err, err_cyc, done_cyc);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy %b need 0", busy_after); end
  endtask
  task automatic test_wrap_race;
    exp_addr.push_back(16'hFFFF);
    exp_addr.push_back(16'h0000);
    exp_data.push_back(16'h7700);
    exp_data.push_back(16'h7701);
    run(1'b0, 16'hFFFF, 2'd1, TO - 1, 16'h7700, 0);
    cmp_queues("wrap");
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL wrap_err: got %0d need 0", n_err); end
  endtask
  task automatic test_busy_ignore;
    exp_addr.push_back(16'h0020);
    exp_addr.push_back(16'h0021);
    exp_data.push_back(16'h3300);
    exp_data.push_back(16'h3301);
    run(1'b0, 16'h0020, 2'd1, 1, 16'h3300, 1);
    cmp_queues("busy");
    checks++;
    if (n_done !== 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL busy_done: got %0d busy %b need 1 0", n_done, busy_after);
    end
  endtask
  task automatic test_mid_reset;
    int n = 0, c = 0;
    req = 1'b1; we = 1'b0; addr = 16'h0200; len = 2'd3; MFC = 1'b0; mem_rdata = 16'h5A5A;
    while (!(n == 2 && rd) && c < 50) begin
      tick;
      c++;
      req = 1'b0;
      if (ldMAR) n++;
      MFC = rd;
    end
    rst = 1'b1; MFC = 1'b0;
    tick;
    checks++;
    if (outs() !== '0 || rdata !== '0) begin
      errors++; $display("FAIL midrst_outs: got %h rdata %h need 0", outs(), rdata);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL midrst_after: got %h need 0", outs()); end
    exp_addr.push_back(16'h0300);
    exp_data.push_back(16'h1234);
    run(1'b0, 16'h0300, 2'd0, 0, 16'h1234, 0);
    cmp_queues("midrst");
    checks++;
    if (n_err !== 0 || n_done !== 1) begin
      errors++; $display("FAIL midrst_redo: err %0d done %0d need 0 1", n_err, n_done);
    end
  endtask
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; len = '0; wdata = '0; mem_rdata = '0; MFC = 1'b0;
    test_reset;
    test_single_read;
    test_burst_write;
    test_timeout;
    test_wrap_race;
    test_busy_ignore;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
